// File: rtl/wb_pkg.sv
// wb_pkg: shared types and the round-robin pick helper for the writeback commit arbiter.
package wb_pkg;
   parameter int WB_XLEN = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_XLEN-1:0]    data;
   } wb_entry_t;

   // First requester strictly after last, wrapping at n; returns last when nothing requests.
   function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] last, input int n);
      logic [2:0] g;
      logic hit;
      int idx;
      g = last;
      hit = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = (int'(last) + k) % n;
         if (k <= n && !hit && req[3'(idx)]) begin
            g = 3'(idx);
            hit = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/wb_commit_arbiter_fifo.sv
// wb_fifo: per-FU result buffer with synchronous clear; full/empty come from the registered count.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;

   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign head  = mem_q[rd_q];

   always_comb begin
      do_push = push && !full && !clr;
      do_pop  = pop && !empty && !clr;
      wr_d    = clr ? '0 : wr_q + AW'(do_push);
      rd_d    = clr ? '0 : rd_q + AW'(do_pop);
      cnt_d   = clr ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end

   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter: buffers FU results and commits them round-robin to the single RF write port.
// Define WB_BYPASS_EN to let a result skip its empty buffer when it wins arbitration.
module wb_commit_arbiter #(
   parameter int NUM_FU    = 3,
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   flush,
   input  logic [NUM_FU-1:0]      fu_valid,
   input  logic [NUM_FU*5-1:0]    fu_rd,
   input  logic [NUM_FU*XLEN-1:0] fu_data,
   output logic [NUM_FU-1:0]      fu_ready,
   output logic                   rf_we,
   output logic [4:0]             rf_waddr,
   output logic [XLEN-1:0]        rf_wdata,
   output logic                   clr_valid,
   output logic [4:0]             clr_rd,
   output logic                   busy
);
   import wb_pkg::*;
   localparam int EW = REG_ADDR_W + XLEN;

   logic [NUM_FU-1:0] full, empty, acc, req, push, pop;
   logic [EW-1:0] head [NUM_FU];
   logic [EW-1:0] sel;
   logic [2:0] grant, last_q, last_d;
   logic rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      wb_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
         .clk   (clk),
         .nrst  (nrst),
         .clr   (flush),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   ({fu_rd[5*i +: 5], fu_data[XLEN*i +: XLEN]}),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end

   always_comb begin
      fu_ready = ~full;
      acc = fu_valid & ~full & {NUM_FU{!flush}};
      for (int i = 0; i < NUM_FU; i++)
         acc[i] = acc[i] && fu_rd[5*i +: 5] != '0;
`ifdef WB_BYPASS_EN
      req = ~empty | acc;
`else
      req = ~empty;
`endif
      grant = rr_next(8'(req), last_q, NUM_FU);
      push = acc;
      pop = '0;
      sel = '0;
      // A granted FU with an empty buffer can only be a bypass candidate.
      for (int i = 0; i < NUM_FU; i++)
         if (grant == 3'(i) && |req && !flush) begin
            pop[i]  = 1'b1;
            sel     = empty[i] ? {fu_rd[5*i +: 5], fu_data[XLEN*i +: XLEN]} : head[i];
            push[i] = acc[i] && !empty[i];
         end
      rf_we_d    = |req && !flush;
      rf_waddr_d = rf_we_d ? sel[XLEN +: REG_ADDR_W] : rf_waddr_q;
      rf_wdata_d = rf_we_d ? sel[XLEN-1:0] : rf_wdata_q;
      last_d     = flush ? 3'(NUM_FU-1) : (|req ? grant : last_q);
   end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         last_q     <= 3'(NUM_FU-1);
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         last_q     <= last_d;
      end

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign clr_valid = rf_we_q;
   assign clr_rd    = rf_waddr_q;
   assign busy      = ~&empty | rf_we_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb_wb_commit_arbiter: directed checks of commit arbitration, back-pressure, rd=0, flush and reset.
module tb_wb_commit_arbiter;
   localparam int N  = 3;
   localparam int XL = 32;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic flush = 1'b0;
   logic [N-1:0] fu_valid = '0;
   logic [N*5-1:0] fu_rd = '0;
   logic [N*XL-1:0] fu_data = '0;
   logic [N-1:0] fu_ready;
   logic rf_we, clr_valid, busy;
   logic [4:0] rf_waddr, clr_rd;
   logic [XL-1:0] rf_wdata;
   int n_pass = 0;
   int n_chk = 0;
   logic [36:0] wlog [$];

   wb_commit_arbiter #(.NUM_FU(N), .XLEN(XL), .BUF_DEPTH(2)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_rd     (fu_rd),
      .fu_data   (fu_data),
      .fu_ready  (fu_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .clr_valid (clr_valid),
      .clr_rd    (clr_rd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rf_we || clr_valid) wlog.push_back({rf_waddr, rf_wdata});

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] d);
      fu_rd[5*i +: 5] = rd;
      fu_data[XL*i +: XL] = d;
   endtask

   task automatic do_reset();
      fu_valid = '0;
      flush = 1'b0;
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
   endtask

   initial begin
      int k;
      logic acc;
      logic [31:0] q1 [$];
      tick();
      chk("rst_we", rf_we, 0);
      chk("rst_clr", clr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", fu_ready, 3'b111);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      nrst = 1'b1;

      set_fu(0, 5'd5, 32'hDEADBEEF);
      fu_valid = 3'b001;
      tick();
      fu_valid = '0;
      chk("single_we_early", rf_we, 0);
      chk("single_busy", busy, 1);
      tick();
      chk("single_we", rf_we, 1);
      chk("single_waddr", rf_waddr, 5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      chk("single_clr", clr_valid, 1);
      chk("single_clr_rd", clr_rd, 5);
      tick();
      chk("single_we_off", rf_we, 0);
      chk("single_idle", busy, 0);

      do_reset();
      for (int i = 0; i < N; i++) set_fu(i, 5'(i + 1), 32'hA0 + i);
      fu_valid = 3'b111;
      for (int n = 0; n < 13; n++) begin
         tick();
         if (n >= 1) begin
            chk("rr_we", rf_we, 1);
            chk("rr_addr", rf_waddr, (n - 1) % 3 + 1);
            chk("rr_data", rf_wdata, 32'hA0 + (n - 1) % 3);
         end
      end
      fu_valid = '0;
      repeat (8) tick();
      chk("rr_drained", busy, 0);

      do_reset();
      wlog.delete();
      set_fu(0, 5'd1, 32'hA0);
      set_fu(2, 5'd3, 32'hA2);
      k = 0;
      for (int c = 0; c < 20; c++) begin
         fu_valid = {1'b1, k < 4, 1'b1};
         set_fu(1, 5'd2, 32'hB0 + k);
         acc = fu_valid[1] && fu_ready[1];
         tick();
         if (acc) k++;
         if (c == 1) begin
            chk("bp_ready1", fu_ready[1], 0);
            chk("bp_accepts", k, 2);
         end
      end
      fu_valid = '0;
      repeat (10) tick();
      chk("bp_all_sent", k, 4);
      foreach (wlog[i]) if (wlog[i][36:32] == 5'd2) q1.push_back(wlog[i][31:0]);
      chk("bp_count", q1.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("bp_order", i < q1.size() ? q1[i] : 32'hFFFFFFFF, 32'hB0 + i);

      do_reset();
      wlog.delete();
      set_fu(2, 5'd0, 32'h1234);
      fu_valid = 3'b100;
      chk("rd0_ready", fu_ready[2], 1);
      tick();
      fu_valid = '0;
      chk("rd0_busy", busy, 0);
      chk("rd0_ready_after", fu_ready, 3'b111);
      repeat (3) tick();
      chk("rd0_no_write", wlog.size(), 0);

      do_reset();
      wlog.delete();
      set_fu(0, 5'd1, 32'hC0);
      set_fu(1, 5'd2, 32'hC1);
      set_fu(2, 5'd3, 32'hC2);
      fu_valid = 3'b111;
      tick();
      fu_valid = 3'b110;
      tick();
      chk("fl_pre_we", rf_we, 1);
      chk("fl_pre_addr", rf_waddr, 1);
      chk("fl_pre_ready", fu_ready, 3'b001);
      flush = 1'b1;
      set_fu(0, 5'd9, 32'hC9);
      fu_valid = 3'b001;
      tick();
      flush = 1'b0;
      fu_valid = '0;
      chk("fl_we", rf_we, 0);
      chk("fl_clr", clr_valid, 0);
      chk("fl_ready", fu_ready, 3'b111);
      chk("fl_busy", busy, 0);
      set_fu(0, 5'd4, 32'hD0);
      set_fu(1, 5'd5, 32'hD1);
      set_fu(2, 5'd6, 32'hD2);
      fu_valid = 3'b111;
      tick();
      fu_valid = '0;
      tick();
      chk("fl_next_we", rf_we, 1);
      chk("fl_next_addr", rf_waddr, 4);
      repeat (5) tick();
      chk("fl_log_size", wlog.size(), 4);
      chk("fl_log_first", wlog.size() > 0 ? wlog[0][36:32] : 5'h1F, 1);
      chk("fl_log_second", wlog.size() > 1 ? wlog[1][36:32] : 5'h1F, 4);

      do_reset();
      fu_valid = 3'b111;
      tick();
      tick();
      chk("mid_pre_we", rf_we, 1);
      nrst = 1'b0;
      #1;
      chk("mid_we", rf_we, 0);
      chk("mid_clr", clr_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_ready", fu_ready, 3'b111);
      fu_valid = '0;
      #1;
      nrst = 1'b1;
      tick();
      chk("mid_after_we", rf_we, 0);
      chk("mid_after_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
